frame_draw_sequencer: RTL and testbench
=======================================

Name: frame_draw_sequencer

Overview:
- Per-frame scheduler that owns the VGA plot port and shares it between three drawing clients in fixed order: screen clear, column drawer, bird drawer.
- Starts each client, muxes that client's pixel stream onto the VGA port until it reports done, then waits for the frame tick.
- On each frame tick, advances the horizontal scroll offset that the column drawer consumes.
- Sits between the game FSM (`run`) and the VGA adapter.

Parameters:
- FRAME_TICKS, 833333: clock cycles per frame (60 Hz at 50 MHz); must be >= 2.
- SCROLL_STEP, 1: pixels added to scroll_x per frame; must be < SCREEN_W.
- SCREEN_W, 160: scroll_x modulus.
- WDOG_CYCLES, 65536: per-client watchdog limit; used only with DRAW_WATCHDOG_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  level; 1 = keep sequencing frames
- clr_done, col_done, bird_done  in  1 each  client done levels (may stay high until that client is restarted)
- clr_x, col_x, bird_x  in  8 each  client pixel x
- clr_y, col_y, bird_y  in  7 each  client pixel y
- clr_colour, col_colour, bird_colour  in  3 each  client pixel colour
- clr_draw, col_draw, bird_draw  in  1 each  client plot strobe
- clr_start, col_start, bird_start  out  1 each  one-cycle start pulse to the client
- vga_x  out  8  muxed pixel x
- vga_y  out  7  muxed pixel y
- vga_colour  out  3  muxed pixel colour
- vga_plot  out  1  muxed plot strobe
- grant  out  2  owner: 0 none, 1 clear, 2 columns, 3 bird
- busy  out  1  high in any START/WAIT state
- frame_tick  out  1  one-cycle pulse every FRAME_TICKS cycles
- scroll_x  out  8  column scroll offset, 0..SCREEN_W-1
- overrun  out  1  sticky: a frame tick arrived while drawing
- wdog_err  out  1  sticky watchdog flag; tied 0 without DRAW_WATCHDOG_EN

Behaviour:
- Reset: state IDLE; frame counter 0; scroll_x 0; all starts 0; grant 0; busy 0; frame_tick 0; overrun 0; wdog_err 0; vga_* 0.
- Reset mid-draw aborts immediately; the client is not notified.
- Frame counter:
  - Free-running 0..FRAME_TICKS-1, independent of state.
  - frame_tick is registered and asserted in the cycle after the count reaches FRAME_TICKS-1.
- States: IDLE, S_CLR, W_CLR, S_COL, W_COL, S_BIRD, W_BIRD, FRAME_WAIT.
  - IDLE -> S_CLR when run=1.
  - S_x lasts exactly 1 cycle: x_start=1, grant=x.
  - S_x -> W_x.
  - W_x: done_x is ignored in the first W_x cycle (this masks a stale level from the previous frame) and sampled from the second cycle on.
  - W_x exits on done_x=1: W_CLR -> S_COL, W_COL -> S_BIRD, W_BIRD -> FRAME_WAIT.
  - FRAME_WAIT -> S_CLR on frame_tick when run=1; -> IDLE on frame_tick when run=0.
  - run is sampled only in IDLE and FRAME_WAIT. Dropping run mid-draw finishes the current frame.
- Mux:
  - Combinational, zero latency.
  - In W_x: vga_* = client x signals, and vga_plot = x_draw.
  - In all other states: vga_plot=0, and vga_x/y/colour hold 0.
  - Non-granted clients' draw strobes are ignored.
- Scroll:
  - On every frame_tick, whatever the state: scroll_x <= scroll_x+SCROLL_STEP.
  - If that sum >= SCREEN_W, SCREEN_W is subtracted instead. Compute at 9 bits.
  - Example: SCROLL_STEP=3, scroll_x=158 -> 1.
  - scroll_x does not advance while reset is high.
- Overrun: frame_tick while in any S_x/W_x state sets overrun. The sequence continues, and FRAME_WAIT then waits for the next tick.
- Simultaneous events:
  - done_x in the first W_x cycle is ignored even if it is a genuine fresh done.
  - frame_tick in the same cycle as the W_BIRD exit: overrun is set, and FRAME_WAIT waits for the next tick.

Optional Feature:
- DRAW_WATCHDOG_EN defined:
  - A per-client cycle counter is cleared in S_x and increments in W_x.
  - If it reaches WDOG_CYCLES without done_x: wdog_err is set (sticky) and the FSM proceeds as if done_x had arrived.
- Undefined: no counter; W_x waits indefinitely; wdog_err is constant 0.

Test Plan:
- FRAME_TICKS=64; reset 3 cycles, run=1; each client raises done 10 cycles after its start -> start pulses in order clr, col, bird, each 1 cycle wide; grant sequence 1,2,3,0; then FRAME_WAIT until frame_tick at cycle 64; the next clr_start pulse follows the tick.
- Client done held high permanently from the previous frame -> W_x still lasts >= 2 cycles; no state is skipped.
- col_draw=1, col_x=8'd32, col_y=7'd5, col_colour=3'b111 during W_COL, with clr_draw also 1 -> vga_plot=1, vga_x=32, vga_y=5, vga_colour=7; clear-client values ignored.
- SCROLL_STEP=3, run 54 frames -> scroll_x wraps 159->2; never reads >=160.
- FRAME_TICKS=16, col_done delayed 40 cycles -> overrun=1 and stays 1; the sequence completes, and the subsequent frame start is aligned to a tick.
- With DRAW_WATCHDOG_EN and WDOG_CYCLES=8, bird_done never asserted -> wdog_err=1 after 8 W_BIRD cycles, state FRAME_WAIT; reset asserted mid-W_COL -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/frame_draw_sequencer.sv
// Per-frame scheduler that shares the VGA plot port between the clear, column and bird drawers.
// Optional per-client watchdog enabled by defining DRAW_WATCHDOG_EN.
module frame_draw_sequencer #(
  parameter int unsigned FRAME_TICKS = 833333,
  parameter int unsigned SCROLL_STEP = 1,
  parameter int unsigned SCREEN_W    = 160
`ifdef DRAW_WATCHDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES = 65536
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       clr_done,
  input  logic       col_done,
  input  logic       bird_done,
  input  logic [7:0] clr_x,
  input  logic [7:0] col_x,
  input  logic [7:0] bird_x,
  input  logic [6:0] clr_y,
  input  logic [6:0] col_y,
  input  logic [6:0] bird_y,
  input  logic [2:0] clr_colour,
  input  logic [2:0] col_colour,
  input  logic [2:0] bird_colour,
  input  logic       clr_draw,
  input  logic       col_draw,
  input  logic       bird_draw,
  output logic       clr_start,
  output logic       col_start,
  output logic       bird_start,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [1:0] grant,
  output logic       busy,
  output logic       frame_tick,
  output logic [7:0] scroll_x,
  output logic       overrun,
  output logic       wdog_err
);

  localparam int unsigned CntW = (FRAME_TICKS > 2) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CntW-1:0] FrameLast = CntW'(FRAME_TICKS - 1);

  typedef enum logic [2:0] {
    StIdle, StSClr, StWClr, StSCol, StWCol, StSBird, StWBird, StFrameWait
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] frame_cnt_q;
  logic            frame_tick_q;
  logic [7:0]      scroll_q, scroll_next;
  logic [8:0]      scroll_sum;
  logic            first_q;
  logic            clr_start_q, col_start_q, bird_start_q;
  logic [1:0]      grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            overrun_q;
  logic            in_start, in_wait, cur_done, done_ok, wdog_hit, advance;

  // Free-running frame counter, independent of the sequencer state
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q  <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= (frame_cnt_q == FrameLast);
      frame_cnt_q  <= (frame_cnt_q == FrameLast) ? '0 : frame_cnt_q + CntW'(1);
    end
  end

  always_comb begin
    scroll_sum  = {1'b0, scroll_q} + 9'(SCROLL_STEP);
    scroll_next = (scroll_sum >= 9'(SCREEN_W)) ? 8'(scroll_sum - 9'(SCREEN_W)) : scroll_sum[7:0];
  end

  assign in_start = (state_q == StSClr) || (state_q == StSCol) || (state_q == StSBird);
  assign in_wait  = (state_q == StWClr) || (state_q == StWCol) || (state_q == StWBird);

  always_comb begin
    case (state_q)
      StWClr:  cur_done = clr_done;
      StWCol:  cur_done = col_done;
      StWBird: cur_done = bird_done;
      default: cur_done = 1'b0;
    endcase
  end

  // A done level in the first wait cycle may be stale from the previous frame
  assign done_ok = in_wait && !first_q && cur_done;
  assign advance = done_ok || (in_wait && wdog_hit);

`ifdef DRAW_WATCHDOG_EN
  logic [31:0] wdog_cnt_q;
  logic        wdog_err_q;

  assign wdog_hit = (wdog_cnt_q == 32'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (in_start) begin
        wdog_cnt_q <= '0;
      end else if (in_wait) begin
        wdog_cnt_q <= wdog_cnt_q + 32'd1;
      end
      if (in_wait && wdog_hit && !done_ok) begin
        wdog_err_q <= 1'b1;
      end
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_hit = 1'b0;
  assign wdog_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (run) state_d = StSClr;
      StSClr:      state_d = StWClr;
      StWClr:      if (advance) state_d = StSCol;
      StSCol:      state_d = StWCol;
      StWCol:      if (advance) state_d = StSBird;
      StSBird:     state_d = StWBird;
      StWBird:     if (advance) state_d = StFrameWait;
      StFrameWait: if (frame_tick_q) state_d = run ? StSClr : StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    case (state_d)
      StSClr, StWClr:   grant_d = 2'd1;
      StSCol, StWCol:   grant_d = 2'd2;
      StSBird, StWBird: grant_d = 2'd3;
      default:          grant_d = 2'd0;
    endcase
    busy_d = (grant_d != 2'd0);
  end

  // Outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      first_q      <= 1'b0;
      clr_start_q  <= 1'b0;
      col_start_q  <= 1'b0;
      bird_start_q <= 1'b0;
      grant_q      <= 2'd0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      scroll_q     <= '0;
    end else begin
      state_q      <= state_d;
      first_q      <= in_start;
      clr_start_q  <= (state_d == StSClr);
      col_start_q  <= (state_d == StSCol);
      bird_start_q <= (state_d == StSBird);
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      if (frame_tick_q && busy_q) begin
        overrun_q <= 1'b1;
      end
      if (frame_tick_q) begin
        scroll_q <= scroll_next;
      end
    end
  end

  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state_q)
      StWClr: begin
        vga_x      = clr_x;
        vga_y      = clr_y;
        vga_colour = clr_colour;
        vga_plot   = clr_draw;
      end
      StWCol: begin
        vga_x      = col_x;
        vga_y      = col_y;
        vga_colour = col_colour;
        vga_plot   = col_draw;
      end
      StWBird: begin
        vga_x      = bird_x;
        vga_y      = bird_y;
        vga_colour = bird_colour;
        vga_plot   = bird_draw;
      end
      default: ;
    endcase
  end

  assign clr_start  = clr_start_q;
  assign col_start  = col_start_q;
  assign bird_start = bird_start_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign frame_tick = frame_tick_q;
  assign scroll_x   = scroll_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Directed bench for frame_draw_sequencer: FRAME_TICKS=64, SCROLL_STEP=3.
// Watchdog steps use WDOG_CYCLES=8 when DRAW_WATCHDOG_EN is defined.
module tb_frame_draw_sequencer;

  logic       clk = 1'b0;
  logic       reset, run;
  logic       clr_done, col_done, bird_done;
  logic [7:0] clr_x, col_x, bird_x;
  logic [6:0] clr_y, col_y, bird_y;
  logic [2:0] clr_colour, col_colour, bird_colour;
  logic       clr_draw, col_draw, bird_draw;
  logic       clr_start, col_start, bird_start;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [1:0] grant;
  logic       busy, frame_tick, overrun, wdog_err;
  logic [7:0] scroll_x;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int max_scroll;

  frame_draw_sequencer #(
    .FRAME_TICKS(64),
    .SCROLL_STEP(3),
    .SCREEN_W   (160)
`ifdef DRAW_WATCHDOG_EN
    ,
    .WDOG_CYCLES(8)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .clr_done   (clr_done),
    .col_done   (col_done),
    .bird_done  (bird_done),
    .clr_x      (clr_x),
    .col_x      (col_x),
    .bird_x     (bird_x),
    .clr_y      (clr_y),
    .col_y      (col_y),
    .bird_y     (bird_y),
    .clr_colour (clr_colour),
    .col_colour (col_colour),
    .bird_colour(bird_colour),
    .clr_draw   (clr_draw),
    .col_draw   (col_draw),
    .bird_draw  (bird_draw),
    .clr_start  (clr_start),
    .col_start  (col_start),
    .bird_start (bird_start),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .grant      (grant),
    .busy       (busy),
    .frame_tick (frame_tick),
    .scroll_x   (scroll_x),
    .overrun    (overrun),
    .wdog_err   (wdog_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // cyc counts rising edges since reset was released; sampling is 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) cyc = 0;
    else cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, {dut.state_q}, 32'd0);
    chk({tag, "_grant"}, {30'd0, grant}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_starts"}, {29'd0, clr_start, col_start, bird_start}, 32'd0);
    chk({tag, "_tick"}, {31'd0, frame_tick}, 32'd0);
    chk({tag, "_scroll"}, {24'd0, scroll_x}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    chk({tag, "_wdog"}, {31'd0, wdog_err}, 32'd0);
    chk({tag, "_vga"}, {13'd0, vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0;
    clr_done = 1'b0; col_done = 1'b0; bird_done = 1'b0;
    clr_x = '0; col_x = '0; bird_x = '0;
    clr_y = '0; col_y = '0; bird_y = '0;
    clr_colour = '0; col_colour = '0; bird_colour = '0;
    clr_draw = 1'b0; col_draw = 1'b0; bird_draw = 1'b0;

    // Reset state
    repeat (3) tick();
    chk_reset("rst");

    // Normal frame: each client done 10 cycles after its start
    run = 1'b1; reset = 1'b0;
    tick();
    chk("f1_clr_start", {31'd0, clr_start}, 32'd1);
    chk("f1_grant_s_clr", {30'd0, grant}, 32'd1);
    chk("f1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("f1_clr_start_width", {31'd0, clr_start}, 32'd0);
    chk("f1_grant_w_clr", {30'd0, grant}, 32'd1);
    goto(11); clr_done = 1'b1;
    tick(); clr_done = 1'b0;
    chk("f1_col_start", {29'd0, clr_start, col_start, bird_start}, 32'd2);
    chk("f1_grant_col", {30'd0, grant}, 32'd2);
    tick();
    chk("f1_col_start_width", {31'd0, col_start}, 32'd0);
    goto(22); col_done = 1'b1;
    tick(); col_done = 1'b0;
    chk("f1_bird_start", {29'd0, clr_start, col_start, bird_start}, 32'd1);
    chk("f1_grant_bird", {30'd0, grant}, 32'd3);
    goto(33); bird_done = 1'b1;
    tick(); bird_done = 1'b0;
    chk("f1_grant_wait", {30'd0, grant}, 32'd0);
    chk("f1_busy_wait", {31'd0, busy}, 32'd0);
    goto(63);
    chk("f1_tick_early", {31'd0, frame_tick}, 32'd0);
    tick();
    chk("f1_tick", {31'd0, frame_tick}, 32'd1);
    chk("f1_no_start_on_tick", {31'd0, clr_start}, 32'd0);
    tick();
    chk("f2_clr_start", {31'd0, clr_start}, 32'd1);
    chk("f2_tick_width", {31'd0, frame_tick}, 32'd0);
    chk("f2_scroll", {24'd0, scroll_x}, 32'd3);

    // Stale done levels: every wait state still lasts two cycles
    clr_done = 1'b1; col_done = 1'b1; bird_done = 1'b1;
    tick();
    chk("stale_w_clr_1", {30'd0, grant}, 32'd1);
    tick();
    chk("stale_w_clr_2", {30'd0, grant, col_start}, 32'd2);
    tick();
    chk("stale_col_start", {31'd0, col_start}, 32'd1);
    goto(71);
    chk("stale_bird_start", {31'd0, bird_start}, 32'd1);
    goto(73);
    chk("stale_w_bird_2", {30'd0, grant}, 32'd3);
    tick();
    chk("stale_frame_wait", {29'd0, grant, busy}, 32'd0);
    clr_done = 1'b0; col_done = 1'b0; bird_done = 1'b0;

    // Mux: granted client only, zero latency, zero outside wait states
    goto(129);
    chk("f3_clr_start", {31'd0, clr_start}, 32'd1);
    tick();
    clr_draw = 1'b1; clr_x = 8'd10; clr_y = 7'd20; clr_colour = 3'd3;
    #1;
    chk("mux_clr", {13'd0, vga_plot, vga_x, vga_y, vga_colour}, {13'd0, 1'b1, 8'd10, 7'd20, 3'd3});
    goto(131); clr_done = 1'b1;
    tick(); clr_done = 1'b0;
    col_draw = 1'b1; col_x = 8'd32; col_y = 7'd5; col_colour = 3'b111;
    #1;
    chk("mux_s_col_zero", {13'd0, vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
    tick();
    chk("mux_col", {13'd0, vga_plot, vga_x, vga_y, vga_colour}, {13'd0, 1'b1, 8'd32, 7'd5, 3'd7});
    col_draw = 1'b0;
    #1;
    chk("mux_col_nodraw", {31'd0, vga_plot}, 32'd0);
    tick(); col_done = 1'b1;
    tick(); col_done = 1'b0;
    chk("f3_bird_start", {31'd0, bird_start}, 32'd1);
    tick(); bird_done = 1'b1;  // fresh done in the first wait cycle is ignored
    tick();
    chk("first_cycle_done_ignored", {30'd0, grant, busy}, 32'd7);
    tick(); bird_done = 1'b0; clr_draw = 1'b0;
    chk("f3_frame_wait", {30'd0, grant}, 32'd0);

    // Overrun: column drawer stalls across a frame tick
    goto(193);
    chk("f4_clr_start", {31'd0, clr_start}, 32'd1);
    goto(195); clr_done = 1'b1;
    tick(); clr_done = 1'b0;
    chk("f4_col_start", {31'd0, col_start}, 32'd1);
    goto(256);
    chk("ovr_tick_in_draw", {30'd0, frame_tick, overrun}, 32'd2);
    tick();
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    chk("ovr_still_col", {30'd0, grant}, 32'd2);
    chk("ovr_scroll", {24'd0, scroll_x}, 32'd12);
    goto(260); col_done = 1'b1;
    tick(); col_done = 1'b0;
    chk("ovr_bird_start", {31'd0, bird_start}, 32'd1);
    goto(263); bird_done = 1'b1;
    tick(); bird_done = 1'b0;
    chk("ovr_frame_wait", {30'd0, grant, overrun}, 32'd1);
    goto(320);
    chk("ovr_wait_tick", {30'd0, frame_tick, clr_start}, 32'd2);
    tick();
    chk("ovr_aligned_start", {31'd0, clr_start}, 32'd1);
    chk("ovr_scroll2", {24'd0, scroll_x}, 32'd15);

    // Scroll wrap over 54 frames with clients always done
    clr_done = 1'b1; col_done = 1'b1; bird_done = 1'b1;
    max_scroll = 0;
    while (cyc < 3457) begin
      tick();
      if (int'(scroll_x) > max_scroll) max_scroll = int'(scroll_x);
      if (cyc == 3393) chk("scroll_159", {24'd0, scroll_x}, 32'd159);
    end
    chk("scroll_wrap_2", {24'd0, scroll_x}, 32'd2);
    chk("scroll_max", max_scroll, 32'd159);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    chk("f54_clr_start", {31'd0, clr_start}, 32'd1);

    // Reset mid-W_COL aborts at once
    goto(3461);
    chk("pre_rst_w_col", {29'd0, grant, col_start}, 32'd4);
    col_draw = 1'b1;
    #1;
    chk("pre_rst_plot", {31'd0, vga_plot}, 32'd1);
    reset = 1'b1;
    tick();
    chk_reset("midrst");
    clr_done = 1'b0; col_done = 1'b0; bird_done = 1'b0; col_draw = 1'b0;
    tick();

    // Bird never reports done
    reset = 1'b0;
    tick();
    chk("w_clr_start", {31'd0, clr_start}, 32'd1);
    goto(3); clr_done = 1'b1;
    tick(); clr_done = 1'b0;
    chk("w_col_start", {31'd0, col_start}, 32'd1);
    goto(6); col_done = 1'b1;
    tick(); col_done = 1'b0;
    chk("w_bird_start", {31'd0, bird_start}, 32'd1);
    goto(15);
    chk("w_bird_8th", {29'd0, grant, wdog_err}, 32'd6);
`ifdef DRAW_WATCHDOG_EN
    tick();
    chk("wdog_err_set", {31'd0, wdog_err}, 32'd1);
    chk("wdog_frame_wait", {30'd0, grant, busy}, 32'd0);
`else
    goto(20);
    chk("no_wdog_waits", {29'd0, grant, wdog_err}, 32'd6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
